// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multi-cycle fetch/decode/execute/update sequencer owning pc and flags
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter int          MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  input  logic        dec_branch,
  input  logic        dec_uncond,
  input  logic [2:0]  dec_cond,
  input  logic        dec_adsel,
  input  logic        dec_flags_we,
  input  logic        dec_halt,
  output logic        exec_start,
  input  logic        exec_done,
  input  logic [2:0]  alu_flags,
  output logic [31:0] pc,
  output logic        ad_sel,
  output logic        unconditional,
  output logic [2:0]  conditional,
  output logic [2:0]  flags,
  input  logic [31:0] next_address,
  output logic        busy,
  output logic        halted,
  output logic        error,
  output logic [31:0] instr_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;
  localparam logic [2:0] S_HALTED = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  // Last fetch-wait count before giving up on instruction memory.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [2:0]  flags_q, flags_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        exec_start_q, exec_start_d;
  // Decode results held from DECODE until the instruction's UPDATE.
  logic        br_q, br_d;
  logic        un_q, un_d;
  logic [2:0]  cond_q, cond_d;
  logic        ads_q, ads_d;
  logic        fwe_q, fwe_d;
  // ALU flags captured on exec_done, committed in UPDATE.
  logic [2:0]  alu_q, alu_d;

  logic        in_update;
  logic        jump_live;

  // Next-state and datapath update for every stage of the instruction cycle.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    flags_d      = flags_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    exec_start_d = 1'b0;
    br_d         = br_q;
    un_d         = un_q;
    cond_d       = cond_q;
    ads_d        = ads_q;
    fwe_d        = fwe_q;
    alu_d        = alu_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          tmo_d   = 8'd0;
        end
      end
      S_FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERROR;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_DECODE: begin
        br_d   = dec_branch;
        un_d   = dec_uncond;
        cond_d = dec_cond;
        ads_d  = dec_adsel;
        fwe_d  = dec_flags_we;
        if (dec_halt) begin
          state_d = S_HALTED;
          cnt_d   = cnt_q + 32'd1;
        end else begin
          state_d      = S_EXEC;
          exec_start_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          alu_d   = alu_flags;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        // The jump unit sees the old flags this cycle; a flag write lands at the same edge as the new pc.
        pc_d  = next_address;
        cnt_d = cnt_q + 32'd1;
        if (fwe_q) begin
          flags_d = alu_q;
        end
        state_d = S_FETCH;
        tmo_d   = 8'd0;
      end
      S_HALTED: state_d = S_HALTED;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_ERROR;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      ir_q         <= 32'd0;
      flags_q      <= 3'b000;
      cnt_q        <= 32'd0;
      tmo_q        <= 8'd0;
      exec_start_q <= 1'b0;
      br_q         <= 1'b0;
      un_q         <= 1'b0;
      cond_q       <= 3'b000;
      ads_q        <= 1'b0;
      fwe_q        <= 1'b0;
      alu_q        <= 3'b000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      flags_q      <= flags_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      exec_start_q <= exec_start_d;
      br_q         <= br_d;
      un_q         <= un_d;
      cond_q       <= cond_d;
      ads_q        <= ads_d;
      fwe_q        <= fwe_d;
      alu_q        <= alu_d;
    end
  end

  assign in_update = (state_q == S_UPDATE);
  // Non-branch instructions present a plain pc+1 request to the jump unit.
  assign jump_live = in_update & br_q;

  assign imem_req      = (state_q == S_FETCH);
  assign imem_addr     = pc_q;
  assign ir            = ir_q;
  assign exec_start    = exec_start_q;
  assign pc            = pc_q;
  assign ad_sel        = jump_live & ads_q;
  assign unconditional = jump_live & un_q;
  assign conditional   = jump_live ? cond_q : 3'b000;
  assign flags         = flags_q;
  assign busy          = (state_q != S_IDLE) && (state_q != S_HALTED) && (state_q != S_ERROR);
  assign halted        = (state_q == S_HALTED);
  assign error         = (state_q == S_ERROR);
  assign instr_count   = cnt_q;

endmodule
